// File: rtl/multi_dataflow_engine_ctrl.sv
// multi_dataflow_engine_ctrl
//   Engine-side control stage placed right after the HWPE main FSM.
//   - Sequences IDLE -> RUN -> DONE -> IDLE from the ctrl_engine bundle.
//   - Gates the inStream0 handshake into the multi-dataflow kernel.
//   - Buffers kernel results in a small FIFO ahead of outStream0.
//   - Counts delivered outputs and reports them through the flags bundle.
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   clear_i, ctrl_clear_i      soft clears (same effect as reset)
//   ctrl_*                     enable/start/limit/frame geometry/config
//   flags_ready_o/cnt_o/done_o idle flag, delivered count, done pulse
//   in_* / k_in_*              inStream0 -> kernel input (combinational gate)
//   k_out_* / out_*            kernel output -> FIFO -> outStream0
//   k_clear_o, k_config_o, k_width_o, k_height_o  kernel side-band
module multi_dataflow_engine_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned CFG_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  ctrl_clear_i,
    input  logic                  ctrl_enable_i,
    input  logic                  ctrl_start_i,
    input  logic [CNT_WIDTH-1:0]  ctrl_cnt_limit_i,
    input  logic [15:0]           ctrl_width_i,
    input  logic [15:0]           ctrl_height_i,
    input  logic [CFG_WIDTH-1:0]  ctrl_configuration_i,
    output logic                  flags_ready_o,
    output logic [CNT_WIDTH-1:0]  flags_cnt_o,
    output logic                  flags_done_o,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  k_in_valid_o,
    input  logic                  k_in_ready_i,
    output logic [DATA_WIDTH-1:0] k_in_data_o,
    input  logic                  k_out_valid_i,
    output logic                  k_out_ready_o,
    input  logic [DATA_WIDTH-1:0] k_out_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  k_clear_o,
    output logic [CFG_WIDTH-1:0]  k_config_o,
    output logic [15:0]           k_width_o,
    output logic [15:0]           k_height_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   limit;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [15:0]            width_q;
    logic [15:0]            height_q;
    logic [CFG_WIDTH-1:0]   cfg_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr;
    logic [PTR_W:0]         rd_ptr;
    logic [PTR_W:0]         fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic                   clr;
    logic                   run_en;
    logic                   below_limit;
    logic                   push;
    logic                   pop;

    assign clr        = clear_i | ctrl_clear_i;
    assign k_clear_o  = clr;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);

    // Results already buffered count against the limit, so the kernel can
    // never be acknowledged for more than `limit` words in one run. One extra
    // bit keeps the sum from wrapping at the top of the counter range.
    assign below_limit = ({1'b0, cnt} + (CNT_WIDTH+1)'(fifo_count)) < {1'b0, limit};

    assign run_en        = (state == RUN) & ctrl_enable_i;

    assign k_in_valid_o  = in_valid_i & run_en;
    assign in_ready_o    = k_in_ready_i & run_en;
    assign k_in_data_o   = in_data_i;

    assign k_out_ready_o = run_en & ~fifo_full & below_limit;
    assign out_valid_o   = run_en & ~fifo_empty;
    assign out_data_o    = mem[rd_ptr[PTR_W-1:0]];

    assign push    = k_out_valid_i & k_out_ready_o;
    assign pop     = out_valid_o & out_ready_i;
    assign cnt_inc = cnt + CNT_WIDTH'(1);

    assign flags_cnt_o = cnt;
    assign k_config_o  = cfg_q;
    assign k_width_o   = width_q;
    assign k_height_o  = height_q;

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= k_out_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            state         <= IDLE;
            cnt           <= '0;
            limit         <= '0;
            width_q       <= '0;
            height_q      <= '0;
            cfg_q         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            flags_ready_o <= 1'b1;
            flags_done_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
                cnt    <= cnt_inc;
            end
            unique case (state)
                IDLE: begin
                    if (ctrl_start_i && ctrl_enable_i) begin
                        limit         <= ctrl_cnt_limit_i;
                        width_q       <= ctrl_width_i;
                        height_q      <= ctrl_height_i;
                        cfg_q         <= ctrl_configuration_i;
                        cnt           <= '0;
                        flags_ready_o <= 1'b0;
                        if (ctrl_cnt_limit_i == '0) begin
                            state        <= DONE;
                            flags_done_o <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pop && (cnt_inc == limit)) begin
                        state        <= DONE;
                        flags_done_o <= 1'b1;
                    end
                end
                DONE: begin
                    // Enable low freezes the FSM here as in every state.
                    if (ctrl_enable_i) begin
                        state         <= IDLE;
                        flags_done_o  <= 1'b0;
                        flags_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    flags_done_o  <= 1'b0;
                    flags_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_dataflow_engine_ctrl.sv
// Directed bench for multi_dataflow_engine_ctrl (FIFO_DEPTH = 2).
module tb_multi_dataflow_engine_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        clear_i, ctrl_clear_i, ctrl_enable_i, ctrl_start_i;
    logic [31:0] ctrl_cnt_limit_i;
    logic [15:0] ctrl_width_i, ctrl_height_i;
    logic [7:0]  ctrl_configuration_i;
    logic        flags_ready_o, flags_done_o;
    logic [31:0] flags_cnt_o;
    logic        in_valid_i, in_ready_o, k_in_valid_o, k_in_ready_i;
    logic [31:0] in_data_i, k_in_data_o;
    logic        k_out_valid_i, k_out_ready_o, out_valid_o, out_ready_i;
    logic [31:0] k_out_data_i, out_data_o;
    logic        k_clear_o;
    logic [7:0]  k_config_o;
    logic [15:0] k_width_o, k_height_o;

    int n_vec = 0;
    int n_err = 0;

    multi_dataflow_engine_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .ctrl_clear_i(ctrl_clear_i),
        .ctrl_enable_i(ctrl_enable_i), .ctrl_start_i(ctrl_start_i),
        .ctrl_cnt_limit_i(ctrl_cnt_limit_i), .ctrl_width_i(ctrl_width_i),
        .ctrl_height_i(ctrl_height_i), .ctrl_configuration_i(ctrl_configuration_i),
        .flags_ready_o(flags_ready_o), .flags_cnt_o(flags_cnt_o), .flags_done_o(flags_done_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .k_in_valid_o(k_in_valid_o), .k_in_ready_i(k_in_ready_i), .k_in_data_o(k_in_data_o),
        .k_out_valid_i(k_out_valid_i), .k_out_ready_o(k_out_ready_o), .k_out_data_i(k_out_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .k_clear_o(k_clear_o), .k_config_o(k_config_o), .k_width_o(k_width_o),
        .k_height_o(k_height_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] lim);
        ctrl_cnt_limit_i = lim;
        ctrl_start_i     = 1'b1;
        tick();
        ctrl_start_i     = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, pops, n;
        rst_i = 1; clear_i = 0; ctrl_clear_i = 0; ctrl_enable_i = 0; ctrl_start_i = 0;
        ctrl_cnt_limit_i = 0; ctrl_width_i = 16'd10; ctrl_height_i = 16'd20;
        ctrl_configuration_i = 8'h5; in_valid_i = 0; k_in_ready_i = 0; in_data_i = 32'h1234;
        k_out_valid_i = 0; k_out_data_i = 0; out_ready_i = 0;
        tick(); tick();
        rst_i = 0;
        #1;
        chk("rst_ready", flags_ready_o, 1);
        chk("rst_done", flags_done_o, 0);
        chk("rst_cnt", flags_cnt_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_k_out_ready", k_out_ready_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_k_in_valid", k_in_valid_o, 0);
        chk("rst_k_config", k_config_o, 0);

        // Basic run, limit 4
        ctrl_enable_i = 1; in_valid_i = 1; k_in_ready_i = 1; ctrl_cnt_limit_i = 4;
        ctrl_start_i = 1;
        #1;
        chk("idle_k_in_valid", k_in_valid_o, 0);
        tick();
        ctrl_start_i = 0;
        k_out_valid_i = 1; k_out_data_i = 32'hA0; out_ready_i = 1;
        #1;
        chk("run_ready", flags_ready_o, 0);
        chk("run_config", k_config_o, 8'h5);
        chk("run_width", k_width_o, 16'd10);
        chk("run_height", k_height_o, 16'd20);
        chk("run_k_in_valid", k_in_valid_o, 1);
        chk("run_in_ready", in_ready_o, 1);
        chk("run_k_in_data", k_in_data_o, 32'h1234);
        chk("run_k_out_ready0", k_out_ready_o, 1);
        chk("run_out_valid0", out_valid_o, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            k_out_data_i = 32'hA0 + i;
            #1;
            chk("basic_out_valid", out_valid_o, 1);
            chk("basic_out_data", out_data_o, 32'hA0 + i - 1);
            chk("basic_cnt", flags_cnt_o, i - 1);
            chk("basic_k_out_ready", k_out_ready_o, 1);
        end
        tick();
        k_out_data_i = 32'hA4;
        #1;
        chk("basic_last_data", out_data_o, 32'hA3);
        chk("basic_cnt3", flags_cnt_o, 3);
        chk("basic_limit_gate", k_out_ready_o, 0);
        tick();
        chk("basic_done", flags_done_o, 1);
        chk("basic_cnt4", flags_cnt_o, 4);
        chk("basic_done_ready", flags_ready_o, 0);
        chk("basic_done_out_valid", out_valid_o, 0);
        chk("basic_done_k_out_ready", k_out_ready_o, 0);
        tick();
        chk("basic_done_once", flags_done_o, 0);
        chk("basic_idle_ready", flags_ready_o, 1);
        chk("basic_cnt_held", flags_cnt_o, 4);
        k_out_valid_i = 0;

        // Backpressure, limit 3, sink stalled for 10 cycles
        out_ready_i = 0;
        start_run(3);
        k_out_valid_i = 1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            k_out_data_i = 32'hB0 + acc;
            #1;
            if (k_out_ready_o) acc++;
            tick();
        end
        chk("bp_pushes", acc, 2);
        chk("bp_full_gate", k_out_ready_o, 0);
        chk("bp_head", out_data_o, 32'hB0);
        out_ready_i = 1;
        #1;
        chk("bp_pop_full_nopush", k_out_ready_o, 0);
        tick();
        chk("bp_data1", out_data_o, 32'hB1);
        chk("bp_cnt1", flags_cnt_o, 1);
        chk("bp_reopen", k_out_ready_o, 1);
        tick();
        k_out_valid_i = 0;
        #1;
        chk("bp_data2", out_data_o, 32'hB2);
        chk("bp_cnt2", flags_cnt_o, 2);
        chk("bp_limit_gate", k_out_ready_o, 0);
        tick();
        chk("bp_done", flags_done_o, 1);
        chk("bp_cnt3", flags_cnt_o, 3);
        tick();

        // Limit boundary: kernel offers 5 words, limit 3
        start_run(3);
        acc = 0; pops = 0; n = 0;
        while (!flags_done_o && n < 20) begin
            k_out_valid_i = (acc < 5);
            k_out_data_i  = 32'hC0 + acc;
            #1;
            if (out_valid_o && out_ready_i) begin
                chk("lim_order", out_data_o, 32'hC0 + pops);
                pops++;
            end
            if (k_out_valid_i && k_out_ready_o) acc++;
            tick();
            n++;
        end
        chk("lim_done_seen", flags_done_o, 1);
        chk("lim_accepted", acc, 3);
        chk("lim_popped", pops, 3);
        chk("lim_cnt", flags_cnt_o, 3);
        tick();

        // Zero limit
        k_out_valid_i = 1;
        start_run(0);
        #1;
        chk("zero_done", flags_done_o, 1);
        chk("zero_ready", flags_ready_o, 0);
        chk("zero_k_out_ready", k_out_ready_o, 0);
        chk("zero_in_ready", in_ready_o, 0);
        chk("zero_cnt", flags_cnt_o, 0);
        tick();
        chk("zero_done_once", flags_done_o, 0);
        chk("zero_idle", flags_ready_o, 1);

        // Enable pause at cnt 2
        start_run(4);
        for (int i = 0; i < 3; i++) begin
            k_out_data_i = 32'hD0 + i;
            #1;
            chk("pause_pre_k_ready", k_out_ready_o, 1);
            tick();
        end
        ctrl_enable_i = 0;
        k_out_data_i  = 32'hD3;
        #1;
        chk("pause_cnt", flags_cnt_o, 2);
        chk("pause_out_valid", out_valid_o, 0);
        chk("pause_k_out_ready", k_out_ready_o, 0);
        chk("pause_in_ready", in_ready_o, 0);
        chk("pause_k_in_valid", k_in_valid_o, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pause_cnt_hold", flags_cnt_o, 2);
            chk("pause_valid_hold", out_valid_o, 0);
        end
        ctrl_enable_i = 1;
        #1;
        chk("resume_data", out_data_o, 32'hD2);
        chk("resume_k_ready", k_out_ready_o, 1);
        tick();
        chk("resume_data3", out_data_o, 32'hD3);
        chk("resume_cnt3", flags_cnt_o, 3);
        chk("resume_gate", k_out_ready_o, 0);
        tick();
        chk("resume_done", flags_done_o, 1);
        chk("resume_cnt4", flags_cnt_o, 4);
        k_out_valid_i = 0;
        tick();
        chk("resume_idle", flags_ready_o, 1);

        // Clear mid-run with a simultaneous start
        start_run(4);
        k_out_valid_i = 1; k_out_data_i = 32'hE0; out_ready_i = 0;
        #1;
        chk("clr_k_clear_lo", k_clear_o, 0);
        tick();
        k_out_data_i = 32'hE1; out_ready_i = 1;
        tick();
        k_out_valid_i = 0; out_ready_i = 0;
        #1;
        chk("clr_pre_cnt", flags_cnt_o, 1);
        chk("clr_pre_entry", out_data_o, 32'hE1);
        ctrl_clear_i = 1; ctrl_start_i = 1;
        #1;
        chk("clr_k_clear_hi", k_clear_o, 1);
        tick();
        ctrl_clear_i = 0; ctrl_start_i = 0;
        #1;
        chk("clr_ready", flags_ready_o, 1);
        chk("clr_cnt", flags_cnt_o, 0);
        chk("clr_done", flags_done_o, 0);
        chk("clr_width", k_width_o, 0);
        out_ready_i = 1;
        start_run(4);
        #1;
        chk("clr_fifo_empty", out_valid_o, 0);
        chk("clr_new_run", flags_ready_o, 0);
        clear_i = 1;
        #1;
        chk("gclr_k_clear", k_clear_o, 1);
        tick();
        clear_i = 0;
        #1;
        chk("gclr_ready", flags_ready_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
